// File: rtl/banco_pkg.sv
// Shared defaults and pointer type for the multi-port register bank.
package banco_pkg;

    localparam int unsigned N_DEF    = 32;
    localparam int unsigned BITS_DEF = 64;
    localparam int unsigned NR_DEF   = 2;

    typedef logic [$clog2(N_DEF)-1:0] ptr_t;

endpackage

// File: rtl/celda_registro.sv
// One Bits-wide architectural register with load enable and async active-low clear.
module celda_registro #(
    parameter int unsigned Bits = 64
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            en,
    input  logic [Bits-1:0] d,
    output logic [Bits-1:0] q
);

    // Load d when enabled; clear immediately while rst is low.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            q <= '0;
        end else if (en) begin
            q <= d;
        end
    end

endmodule

// File: rtl/banco_registros_mp.sv
// Multi-port register file with two writeback ports, same-cycle forwarding
// and a per-register busy scoreboard. Register 0 is hardwired to zero.
module banco_registros_mp
    import banco_pkg::*;
#(
    parameter int unsigned N    = N_DEF,
    parameter int unsigned Bits = BITS_DEF,
    parameter int unsigned NR   = NR_DEF
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NR*$clog2(N)-1:0] ptr_rd,
    output logic [NR*Bits-1:0]      data_rd,
    output logic [NR-1:0]           busy_rd,
    input  logic                    wr_en_a,
    input  logic [$clog2(N)-1:0]    ptr_wr_a,
    input  logic [Bits-1:0]         data_wr_a,
    input  logic                    wr_en_b,
    input  logic [$clog2(N)-1:0]    ptr_wr_b,
    input  logic [Bits-1:0]         data_wr_b,
    input  logic                    issue_en,
    input  logic [$clog2(N)-1:0]    issue_ptr
);

    localparam int unsigned PW = $clog2(N);

    logic [Bits-1:0] regs [N];
    logic [N-1:0]    busy;
    logic [N-1:0]    hit_a;
    logic [N-1:0]    hit_b;
    logic [N-1:0]    hit_issue;

    // One-hot write/issue decode; bit 0 is never set so register 0 stays inert.
    always_comb begin
        hit_a     = '0;
        hit_b     = '0;
        hit_issue = '0;
        for (int unsigned i = 1; i < N; i++) begin
            hit_a[i]     = wr_en_a  && (ptr_wr_a  == PW'(i));
            hit_b[i]     = wr_en_b  && (ptr_wr_b  == PW'(i));
            hit_issue[i] = issue_en && (issue_ptr == PW'(i));
        end
    end

    assign regs[0] = '0;

    for (genvar gi = 1; gi < N; gi++) begin : g_celda
        celda_registro #(
            .Bits(Bits)
        ) u_celda (
            .clk(clk),
            .rst(rst),
            .en (hit_a[gi] | hit_b[gi]),
            .d  (hit_b[gi] ? data_wr_b : data_wr_a),
            .q  (regs[gi])
        );
    end

    // Scoreboard: writes clear, issue sets; set is applied last so a new producer wins.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            busy <= '0;
        end else begin
            busy <= (busy & ~(hit_a | hit_b)) | hit_issue;
        end
    end

    // Combinational read with forwarding; outputs forced to zero while in reset.
    always_comb begin
        logic [PW-1:0] p;
        data_rd = '0;
        busy_rd = '0;
        p       = '0;
        for (int unsigned k = 0; k < NR; k++) begin
            p = ptr_rd[k*PW +: PW];
            if (rst) begin
                if (hit_b[p]) begin
                    data_rd[k*Bits +: Bits] = data_wr_b;
                end else if (hit_a[p]) begin
                    data_rd[k*Bits +: Bits] = data_wr_a;
                end else begin
                    data_rd[k*Bits +: Bits] = regs[p];
                end
                busy_rd[k] = busy[p] & ~(hit_a[p] | hit_b[p]);
            end
        end
    end

endmodule

// File: doc/banco_registros_mp.md
BANCO_REGISTROS_MP -- requirements
Module: banco_registros_mp

Interface
REQ-001 Parameter N, default 32, number of architectural registers; SHALL be a power of two, at least 2.
REQ-002 Parameter Bits, default 64, register data width.
REQ-003 Parameter NR, default 2, number of read ports; SHALL be at least 1.
REQ-004 clk  in  1  single clock; all state SHALL update on its rising edge.
REQ-005 rst  in  1  reset, asynchronous, active-low.
REQ-006 ptr_rd  in  NR x $clog2(N)  read pointer per port.
REQ-007 data_rd  out  NR x Bits  read data per port.
REQ-008 busy_rd  out  NR  scoreboard busy flag per read port.
REQ-009 wr_en_a, ptr_wr_a, data_wr_a  in  1 / $clog2(N) / Bits  write port A (ALU writeback).
REQ-010 wr_en_b, ptr_wr_b, data_wr_b  in  1 / $clog2(N) / Bits  write port B (memory writeback).
REQ-011 issue_en, issue_ptr  in  1 / $clog2(N)  marks a destination register as pending.

Function
REQ-012 Register 0 SHALL always read zero; writes to it are ignored; it is never busy.
REQ-013 Write on port X: if wr_en_X and ptr_wr_X != 0, the register SHALL take data_wr_X at the next rising edge.
REQ-014 Same-cycle writes from A and B to the same register: port B SHALL win.
REQ-015 Reads SHALL be combinational, with zero-cycle latency.
REQ-016 Bypass: if any enabled write targets ptr_rd[k] (nonzero) this cycle, data_rd[k] SHALL equal that write data. The port B value applies when both ports target it.
REQ-017 Otherwise, data_rd[k] SHALL equal the stored register value.
REQ-018 Scoreboard: busy[issue_ptr] SHALL be set at the next edge when issue_en = 1 and issue_ptr != 0.
REQ-019 An enabled write on A or B SHALL clear busy[ptr] at the next edge.
REQ-020 Simultaneous issue and write to the same register: set SHALL win, because a new producer supersedes the old one.
REQ-021 busy_rd[k] SHALL be busy[ptr_rd[k]], forced to 0 when a same-cycle enabled write targets ptr_rd[k] (the value is forwarded).
REQ-022 All NR ports SHALL be independent; any ports may address the same register.

Reset
REQ-023 While rst = 0, all registers SHALL be 0 and all busy bits 0, asynchronously.
REQ-024 While rst = 0, data_rd SHALL be 0 and busy_rd SHALL be 0 on every port.
REQ-025 Writes and issues presented while rst = 0 SHALL be discarded.
REQ-026 Reset asserted mid-operation SHALL clear pending busy bits without completing in-flight writes.
REQ-027 The first write SHALL take effect at the first rising edge after rst deasserts.

Structure
REQ-028 Package banco_pkg SHALL hold the default N, Bits and NR values and the pointer typedef (logic [$clog2(N)-1:0]).
REQ-029 Sub-module celda_registro SHALL implement one Bits-wide register: enable, asynchronous active-low reset, generated for indices 1..N-1.
REQ-030 Write decode, bypass muxing and the scoreboard SHALL be in the top module; no inverted or derived clocks.

Verification
REQ-031 Reset, then a write via A of reg 5 = 0xA5 -> at the next edge, read port 0 on ptr 5 = 0xA5 and busy_rd = 0.
REQ-032 Same-cycle write A reg 7 = 0x11 and B reg 7 = 0x22, read ptr 7 -> data_rd = 0x22 in that cycle (bypass) and after the edge.
REQ-033 Write reg 0 = 0xFF on both ports -> every port reading ptr 0 returns 0, busy_rd = 0.
REQ-034 Issue reg 3 -> busy_rd = 1 on ptr 3. Next cycle write B reg 3 = 0x33 -> busy_rd = 0 and data_rd = 0x33 same cycle; busy stays cleared after the edge.
REQ-035 Issue reg 9 and write A reg 9 in the same cycle -> after the edge, busy_rd on ptr 9 = 1 and the stored value = the write data.
REQ-036 Fill regs 1..31 with distinct values, pull rst low between edges -> all data_rd = 0 immediately; after release, all registers read 0 and all busy flags are 0.
